sobel_scan_ctrl: RTL and testbench
==================================

# sobel_scan_ctrl

Frame scan controller for the Sobel pipeline. On a start pulse it reads one greyscale frame from image memory in raster order and drives the shift enable of the 3x3 window / line-buffer datapath. For every pixel it emits one result-valid strobe carrying the result write address and a border flag. It supports a downstream hold (stall) and a single-cycle done pulse per frame.

## Interface
Parameters:
- IMG_W, 8, frame width in pixels (>= 3)
- IMG_H, 4, frame height in lines (>= 3)
- ADDR_W, 16, pixel address width; IMG_W*IMG_H must fit in it

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  frame start request; sampled only in IDLE
- hold  in  1  stall; blocks new reads and flush ticks while high
- busy  out  1  frame in progress
- done  out  1  one-cycle end-of-frame pulse
- rd_en  out  1  image memory read enable
- rd_addr  out  ADDR_W  image memory read address
- lb_shift  out  1  window/line-buffer shift enable
- win_valid  out  1  window centre valid; the result for wr_addr is written this cycle
- win_border  out  1  centre lies on the frame border; the result must be forced to 0
- wr_addr  out  ADDR_W  result address (centre pixel index)

## Operation
- States:
  - IDLE: waits for start.
  - RUN: issues all reads.
  - FLUSH: drains the window with dummy shifts.
  - DONE: one-cycle end-of-frame state, then back to IDLE.
- IDLE -> RUN on start=1. Clears the read counter rc, the shift counter sc and the output counter oc. Sets busy=1.
- RUN:
  - rd_en = !hold (combinational); rd_addr = rc.
  - rc increments on each rd_en.
  - The read with rc = IMG_W*IMG_H-1 moves the state to FLUSH.
- Memory read latency is fixed at 1 cycle; lb_q is rd_en registered.
- FLUSH:
  - flush_tick = !lb_q && !hold.
  - The datapath shifts in don't-care data during flush ticks.
- lb_shift = lb_q | flush_tick.
- sc counts lb_shift events.
- win_valid = lb_shift && (sc >= IMG_W+1), using sc before increment.
- wr_addr = oc; oc increments on win_valid.
- Exactly IMG_W*IMG_H win_valid strobes per frame, with wr_addr 0..IMG_W*IMG_H-1 in order.
- win_border = win_valid && (row==0 || row==IMG_H-1 || col==0 || col==IMG_W-1). Row and column counters track oc; they are not derived by division.
- All flush-phase outputs are border pixels by construction.
- When sc reaches IMG_W*IMG_H+IMG_W+1, the state goes to DONE: done=1 for one cycle, busy=0, then IDLE.
- start while not IDLE is ignored. hold in IDLE/DONE has no effect.
- hold does not cancel a read already issued: lb_q still lands one cycle later. The downstream must accept one strobe after asserting hold.

## Timing
- Reset values: busy=0, done=0, rd_en=0, rd_addr=0, lb_shift=0, win_valid=0, win_border=0, wr_addr=0; state IDLE.
- rst is asynchronous and takes effect mid-frame: all counters are cleared and the state returns to IDLE. The next frame requires a new start.
- start sampled at edge N: busy=1 and rd_en=1 (rd_addr=0) from cycle N+1.
- First win_valid (wr_addr=0, border=1) comes IMG_W+2 cycles after the first rd_en, with no hold.
- Unstalled frame: done is high in cycle N + IMG_W*IMG_H + IMG_W + 3.
- hold adds exactly one cycle of latency per held cycle.
- rc, sc and oc stop at their terminal values; there is no wrap inside a frame.

## Configuration
- SOBEL_CTRL_PERF_EN defined:
  - Adds output stall_cnt [15:0].
  - Counts cycles with busy && hold; saturates at 16'hFFFF.
  - Cleared on start acceptance and on reset; holds its value after done.
- SOBEL_CTRL_PERF_EN undefined:
  - The port and its counter are absent.
  - Behaviour is otherwise identical.

## Test plan
- Basic frame, IMG_W=8, IMG_H=4, start at cycle 0, hold=0:
  - rd_addr 0..31 on consecutive cycles 1..32.
  - 32 win_valid strobes, wr_addr 0..31.
  - done only at cycle 43.
- Border flags, same frame:
  - win_border=0 only for wr_addr 9..14 and 17..22.
  - win_border=1 for the other 20 addresses.
- Stall: hold=1 for 5 cycles at cycle 10 and for 3 cycles during FLUSH:
  - Same address sequences as the basic frame.
  - done at cycle 51.
  - One trailing lb_shift after each hold rise.
- Reset mid-frame: rst=0 at cycle 20 for 2 cycles, then start:
  - All outputs are 0 while rst is low.
  - The next frame restarts at rd_addr=0 and completes normally.
- Start while busy: start pulses at cycles 5 and 40:
  - Both are ignored; a single done.
  - A start one cycle after done begins a new frame.
- With SOBEL_CTRL_PERF_EN: the stall scenario gives stall_cnt=8 after done.

Source files
------------

// File: rtl/sobel_scan_ctrl.sv
// sobel_scan_ctrl: raster-scan read / window-shift / result-strobe sequencer for the Sobel datapath.
// Defining SOBEL_CTRL_PERF_EN adds a saturating stall-cycle counter output (stall_cnt).
module sobel_scan_ctrl #(
  parameter int IMG_W  = 8,
  parameter int IMG_H  = 4,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              hold,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              lb_shift,
  output logic              win_valid,
  output logic              win_border,
`ifdef SOBEL_CTRL_PERF_EN
  output logic [ADDR_W-1:0] wr_addr,
  output logic [15:0]       stall_cnt
`else
  output logic [ADDR_W-1:0] wr_addr
`endif
);
  localparam int NPIX = IMG_W * IMG_H;
  localparam int SC_W = ADDR_W + 1;
  localparam logic [ADDR_W-1:0] RC_LAST  = ADDR_W'(NPIX - 1);
  localparam logic [ADDR_W-1:0] COL_LAST = ADDR_W'(IMG_W - 1);
  localparam logic [ADDR_W-1:0] ROW_LAST = ADDR_W'(IMG_H - 1);
  localparam logic [SC_W-1:0]   SC_FIRST = SC_W'(IMG_W + 1);
  localparam logic [SC_W-1:0]   SC_LAST  = SC_W'(NPIX + IMG_W);
  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;
  state_t state_q;
  logic lb_q, busy_q, done_q, flush_tick;
  logic [ADDR_W-1:0] rc_q, oc_q, row_q, col_q;
  logic [SC_W-1:0] sc_q;
  always_comb begin
    rd_en      = state_q == RUN && !hold;
    flush_tick = state_q == FLUSH && !lb_q && !hold;
    lb_shift   = lb_q | flush_tick;
    win_valid  = lb_shift && sc_q >= SC_FIRST;
    win_border = win_valid && (row_q == '0 || row_q == ROW_LAST || col_q == '0 || col_q == COL_LAST);
    rd_addr    = rc_q;
    wr_addr    = oc_q;
    busy       = busy_q;
    done       = done_q;
  end
  // The window centre lags the read pointer by IMG_W+1 shifts; flush shifts push the tail out.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      lb_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rc_q    <= '0;
      sc_q    <= '0;
      oc_q    <= '0;
      row_q   <= '0;
      col_q   <= '0;
    end else begin
      lb_q <= rd_en;
      if (rd_en) rc_q <= rc_q + ADDR_W'(1);
      if (lb_shift) sc_q <= sc_q + SC_W'(1);
      if (win_valid) begin
        oc_q  <= oc_q + ADDR_W'(1);
        col_q <= col_q == COL_LAST ? '0 : col_q + ADDR_W'(1);
        row_q <= col_q == COL_LAST ? row_q + ADDR_W'(1) : row_q;
      end
      case (state_q)
        IDLE: if (start) begin
          state_q <= RUN;
          busy_q  <= 1'b1;
          rc_q    <= '0;
          sc_q    <= '0;
          oc_q    <= '0;
          row_q   <= '0;
          col_q   <= '0;
        end
        RUN: if (rd_en && rc_q == RC_LAST) state_q <= FLUSH;
        FLUSH: if (lb_shift && sc_q == SC_LAST) begin
          state_q <= DONE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end
        default: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
        end
      endcase
    end
  end
`ifdef SOBEL_CTRL_PERF_EN
  logic [15:0] stall_cnt_q;
  assign stall_cnt = stall_cnt_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) stall_cnt_q <= '0;
    else if (state_q == IDLE && start) stall_cnt_q <= '0;
    else if (busy_q && hold && stall_cnt_q != 16'hFFFF) stall_cnt_q <= stall_cnt_q + 16'd1;
  end
`endif
endmodule

// File: tb/tb_sobel_scan_ctrl.sv
// tb_sobel_scan_ctrl: directed frames with a queue scoreboard checked by a negedge monitor.
module tb_sobel_scan_ctrl;
  localparam int W = 8, H = 4, AW = 16, NP = W * H;
  logic clk = 1'b0, rst = 1'b0, start = 1'b0, hold = 1'b0;
  logic busy, done, rd_en, lb_shift, win_valid, win_border;
  logic [AW-1:0] rd_addr, wr_addr;
`ifdef SOBEL_CTRL_PERF_EN
  logic [15:0] stall_cnt;
`endif
  int checks = 0, failures = 0, cyc = 0, base = 0, nshift = 0;
  int exp_rd[$], exp_wa[$], exp_wb[$], exp_done[$];

  sobel_scan_ctrl #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .hold(hold), .busy(busy), .done(done),
    .rd_en(rd_en), .rd_addr(rd_addr), .lb_shift(lb_shift), .win_valid(win_valid),
    .win_border(win_border),
`ifdef SOBEL_CTRL_PERF_EN
    .wr_addr(wr_addr), .stall_cnt(stall_cnt)
`else
    .wr_addr(wr_addr)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc - base + 1);
    end
  endtask

  function automatic int out_or();
    int v;
    v = int'(busy | done | rd_en | lb_shift | win_valid | win_border | (|rd_addr) | (|wr_addr));
`ifdef SOBEL_CTRL_PERF_EN
    v = v | int'(|stall_cnt);
`endif
    return v;
  endfunction

  always @(negedge clk) if (rst) begin
    if (lb_shift) nshift++;
    if (rd_en) begin
      if (exp_rd.size() == 0) chk("rd_unexpected", 1, 0);
      else chk("rd_addr", int'(rd_addr), exp_rd.pop_front());
    end
    if (win_valid) begin
      if (exp_wa.size() == 0) chk("wr_unexpected", 1, 0);
      else begin
        chk("wr_addr", int'(wr_addr), exp_wa.pop_front());
        chk("win_border", int'(win_border), exp_wb.pop_front());
      end
    end
    if (done) begin
      if (exp_done.size() == 0) chk("done_unexpected", 1, 0);
      else chk("done_cycle", cyc - base + 1, exp_done.pop_front());
    end
  end

  // h1/n1, h2/n2: hold windows; x1/x2: start pulses while busy; rs: reset cycle (0 = none); dc: done cycle
  task automatic frame(input int h1, input int n1, input int h2, input int n2,
                       input int x1, input int x2, input int rs, input int dc);
    int last, r, c;
    for (int a = 0; a < NP; a++) begin
      r = a / W;
      c = a % W;
      exp_rd.push_back(a);
      exp_wa.push_back(a);
      exp_wb.push_back(int'(r == 0 || r == H - 1 || c == 0 || c == W - 1));
    end
    if (rs == 0) exp_done.push_back(dc);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    base = cyc;
    nshift = 0;
    last = rs != 0 ? rs + 1 : dc;
    for (int k = 1; k <= last; k++) begin
      hold = (k >= h1 && k < h1 + n1) || (k >= h2 && k < h2 + n2);
      start = k == x1 || k == x2;
      if (k == rs) begin
        rst = 1'b0;
        exp_rd.delete();
        exp_wa.delete();
        exp_wb.delete();
      end
      @(negedge clk);
      if (k == 1) chk("start_busy_rd0", int'(busy && rd_en && rd_addr == '0), 1);
      if (n1 > 0 && k == h1) chk("hold_trail_shift", int'(lb_shift), 1);
      if (n1 > 0 && k == h1 + 1) chk("hold_no_shift", int'(lb_shift), 0);
      if (rs != 0 && k >= rs) chk("rst_outputs_zero", out_or(), 0);
      @(posedge clk);
      #1;
    end
    hold = 1'b0;
    start = 1'b0;
    if (rs != 0) rst = 1'b1;
    else begin
      chk("rd_left", exp_rd.size(), 0);
      chk("wr_left", exp_wa.size(), 0);
      chk("done_left", exp_done.size(), 0);
      chk("shift_count", nshift, NP + W + 1);
      chk("idle_after_done", int'(busy | done), 0);
    end
  endtask

  initial begin
    #12;
    chk("reset_outputs", out_or(), 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    frame(0, 0, 0, 0, 0, 0, 0, 43);
`ifdef SOBEL_CTRL_PERF_EN
    chk("stall_cnt_nohold", int'(stall_cnt), 0);
`endif
    frame(10, 5, 39, 3, 0, 0, 0, 51);
`ifdef SOBEL_CTRL_PERF_EN
    chk("stall_cnt_stall", int'(stall_cnt), 8);
`endif
    frame(0, 0, 0, 0, 0, 0, 20, 0);
    @(posedge clk);
    #1;
    frame(0, 0, 0, 0, 0, 0, 0, 43);
    frame(0, 0, 0, 0, 5, 40, 0, 43);
    frame(0, 0, 0, 0, 0, 0, 0, 43);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
